baw_game_ctrl: RTL and testbench
================================

Name: baw_game_ctrl

Overview:
- Parametrised Black-and-White game controller; next generation of the board-level game FSM.
- Generalised to NUM_CARDS cards per player with a configurable win target.
- Adds rules the current FSM lacks: legal-selection checking, winner-leads turn order, and early finish.
- Sits between debounced button/switch inputs and the seven-segment/LED renderers; exports all score and hand state for display.

Parameters:
- NUM_CARDS, 9, cards per player; card values 0..NUM_CARDS-1; odd value = black, even = white.
- WIN_TARGET, 5, match wins that end the game early; must satisfy 1 <= WIN_TARGET <= NUM_CARDS.
- CW, $clog2(NUM_CARDS+1), width of the round/score counters (derived; do not override).
- VW, $clog2(NUM_CARDS), width of a card value (derived).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- btn_center, btn_top, btn_bottom, btn_left  in  1 each  single-cycle debounced pulses
- card_sel  in  NUM_CARDS  switch bank; one-hot selects card value = bit index
- state  out  3  current FSM state (encoding in package)
- p1_avail, p2_avail  out  NUM_CARDS  remaining-card masks
- lead_card, follow_card  out  VW  cards committed this round
- lead_is_p2  out  1  1 = player 2 leads the current round
- lead_black, follow_black  out  1  colour of committed cards (valid once committed)
- round  out  CW  completed rounds
- p1_wins, p2_wins  out  CW  match tallies
- match_res  out  2  00 none, 01 p1, 10 p2, 11 draw
- game_res  out  2  same encoding; valid in S_GAME
- sel_err  out  1  registered; high one cycle after a rejected commit

Behaviour:
- Reset (asynchronous, and also on btn_bottom from any state):
  - state = S_IDLE; both avail masks = all ones.
  - All counters, cards, results and lead_is_p2 = 0; sel_err = 0.
- Button priority in a single cycle: bottom > top > left > center. Lower-priority pulses in that cycle are ignored.
- S_IDLE: btn_center -> S_ROUND. Avail masks and counters are re-initialised on this transition.
- S_ROUND: btn_top -> S_LEAD.
- S_LEAD: btn_top is a commit by the leader.
  - Legal iff card_sel is exactly one-hot AND the selected bit is set in the leader's avail mask.
  - Legal commit: lead_card <= encoded value; leader's avail bit cleared; -> S_FOLLOW.
  - Illegal commit: stay in S_LEAD; sel_err pulses for 1 cycle.
- S_FOLLOW: same legality rule applied to the follower's mask.
  - Legal commit: follow_card latched; follower's avail bit cleared; -> S_MATCH.
  - Compare and score update happen on that same edge, so match_res, tallies and round are valid the first cycle in S_MATCH.
  - Scoring: the higher value wins; equal values give a draw (no tally change).
- S_MATCH: on btn_left:
  - Finish condition: p1_wins == WIN_TARGET, or p2_wins == WIN_TARGET, or round == NUM_CARDS.
  - If finished -> S_GAME; game_res = the larger tally, or 11 if equal.
  - Else -> S_ROUND. Next leader = winner of this match; on a draw the leader is unchanged.
  - match_res clears to 00 on entry to S_LEAD.
- S_GAME: holds until btn_bottom.
- Counters saturate at NUM_CARDS; they cannot wrap because round <= NUM_CARDS by construction.
- Player 1 leads round 1.
- The follower may commit any legal card; colour is informational only.
- card_sel is sampled only on a commit edge; changes at other times are ignored.

Optional Feature:
- Macro: BAW_TURN_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYC (default 100_000_000).
  - A counter runs in S_LEAD/S_FOLLOW and resets on every state change.
  - On reaching TIMEOUT_CYC it forces a commit of the lowest-index available card of the acting player.
  - Output to_flag pulses 1 cycle on each forced commit.
- When undefined: no counter, no to_flag port; turns wait indefinitely.

Decomposition:
- Package baw_pkg holds:
  - state encodings S_IDLE=0, S_ROUND=1, S_LEAD=2, S_FOLLOW=3, S_MATCH=4, S_GAME=5;
  - result codes RES_NONE/RES_P1/RES_P2/RES_DRAW;
  - a function is_onehot.
- One sub-module, baw_card_encoder, parametrised by NUM_CARDS:
  - one-hot to binary, plus a valid output (exactly one bit set);
  - also reused for the timeout lowest-set-bit search via a priority mode input.

Test Plan:
- Reset mid-game (S_FOLLOW, round=3): drop reset_n -> same cycle state=0, avail=9'h1FF, tallies 0.
- P1 leads card_sel=9'h010 (4), P2 follows 9'h008 (3) -> match_res=01, p1_wins=1, p1_avail=9'h1EF, p2_avail=9'h1F7, next round lead_is_p2=0.
- Illegal commits:
  - card_sel=9'h011 -> sel_err pulse, state stays S_LEAD;
  - reuse of already-played card 4 -> sel_err pulse.
- Draw: both play 7 -> match_res=11, tallies unchanged, leader unchanged.
- Early finish: P1 wins 5 straight rounds -> after 5th btn_left state=S_GAME, game_res=01, round=5.
- Timeout (BAW_TURN_TIMEOUT_EN, TIMEOUT_CYC=16): no input for 16 cycles in S_LEAD with p1_avail=9'h1FE -> lead_card=1, to_flag pulses once.

Source files
------------

// File: rtl/baw_pkg.sv
// Shared types for the Black-and-White game controller: FSM state codes,
// match/game result codes and a one-hot test helper.
package baw_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ROUND  = 3'd1,
    S_LEAD   = 3'd2,
    S_FOLLOW = 3'd3,
    S_MATCH  = 3'd4,
    S_GAME   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_DRAW = 2'b11
  } res_t;

  // Widest card bank the helper below accepts; narrower banks are zero-extended.
  localparam int MAX_CARDS = 64;

  function automatic logic is_onehot(input logic [MAX_CARDS-1:0] v);
    return (v != '0) && ((v & (v - {{(MAX_CARDS-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/baw_card_encoder.sv
// Card-bank encoder: one-hot to binary with exact-one-hot valid, or (i_prio=1)
// lowest-set-bit search with any-bit-set valid.
module baw_card_encoder
  import baw_pkg::*;
#(
  parameter int NUM_CARDS = 9,
  parameter int VW        = $clog2(NUM_CARDS)
) (
  input  logic [NUM_CARDS-1:0] i_bits,
  input  logic                 i_prio,
  output logic [VW-1:0]        o_value,
  output logic                 o_valid
);

  logic [VW-1:0] w_or_value;
  logic [VW-1:0] w_low_value;

  // Scanning downwards leaves the lowest set index in w_low_value.
  always_comb begin
    w_or_value  = '0;
    w_low_value = '0;
    for (int i = NUM_CARDS - 1; i >= 0; i--) begin
      if (i_bits[i]) begin
        w_or_value  = w_or_value | VW'(i);
        w_low_value = VW'(i);
      end
    end
  end

  assign o_value = i_prio ? w_low_value : w_or_value;
  assign o_valid = i_prio ? (|i_bits) : is_onehot(MAX_CARDS'(i_bits));

endmodule

// File: rtl/baw_game_ctrl.sv
// Black-and-White game controller: turn FSM, legal-selection checks, scoring,
// winner-leads order and early finish. Optional turn timeout: BAW_TURN_TIMEOUT_EN.
module baw_game_ctrl
  import baw_pkg::*;
#(
  parameter int NUM_CARDS   = 9,
  parameter int WIN_TARGET  = 5,
`ifdef BAW_TURN_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 100_000_000,
`endif
  parameter int CW          = $clog2(NUM_CARDS + 1),
  parameter int VW          = $clog2(NUM_CARDS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 btn_center,
  input  logic                 btn_top,
  input  logic                 btn_bottom,
  input  logic                 btn_left,
  input  logic [NUM_CARDS-1:0] card_sel,
  output logic [2:0]           state,
  output logic [NUM_CARDS-1:0] p1_avail,
  output logic [NUM_CARDS-1:0] p2_avail,
  output logic [VW-1:0]        lead_card,
  output logic [VW-1:0]        follow_card,
  output logic                 lead_is_p2,
  output logic                 lead_black,
  output logic                 follow_black,
  output logic [CW-1:0]        round,
  output logic [CW-1:0]        p1_wins,
  output logic [CW-1:0]        p2_wins,
  output logic [1:0]           match_res,
  output logic [1:0]           game_res,
  output logic                 sel_err
`ifdef BAW_TURN_TIMEOUT_EN
  ,
  output logic                 to_flag
`endif
);

  localparam logic [CW-1:0] LP_MAX = CW'(NUM_CARDS);
  localparam logic [CW-1:0] LP_WIN = CW'(WIN_TARGET);

  state_t               r_state;
  logic [NUM_CARDS-1:0] r_p1_avail;
  logic [NUM_CARDS-1:0] r_p2_avail;
  logic [VW-1:0]        r_lead_card;
  logic [VW-1:0]        r_follow_card;
  logic                 r_lead_is_p2;
  logic [CW-1:0]        r_round;
  logic [CW-1:0]        r_p1_wins;
  logic [CW-1:0]        r_p2_wins;
  res_t                 r_match_res;
  res_t                 r_game_res;
  logic                 r_sel_err;

  logic                 w_top;
  logic                 w_left;
  logic                 w_center;
  logic                 w_in_turn;
  logic                 w_actor_is_p2;
  logic [NUM_CARDS-1:0] w_actor_avail;
  logic                 w_force;
  logic                 w_commit;
  logic [NUM_CARDS-1:0] w_enc_in;
  logic [VW-1:0]        w_enc_value;
  logic                 w_enc_valid;
  logic [NUM_CARDS-1:0] w_sel_mask;
  logic                 w_legal;
  logic [VW-1:0]        w_p1_card;
  logic [VW-1:0]        w_p2_card;
  logic                 w_finished;

  // Button priority bottom > top > left > center; btn_bottom is handled first in the FSM.
  assign w_top    = btn_top & ~btn_bottom;
  assign w_left   = btn_left & ~btn_top & ~btn_bottom;
  assign w_center = btn_center & ~btn_left & ~btn_top & ~btn_bottom;

  assign w_in_turn     = (r_state == S_LEAD) || (r_state == S_FOLLOW);
  assign w_actor_is_p2 = (r_state == S_LEAD) ? r_lead_is_p2 : ~r_lead_is_p2;
  assign w_actor_avail = w_actor_is_p2 ? r_p2_avail : r_p1_avail;
  assign w_commit      = w_in_turn && (w_top || w_force);

  // A forced commit searches the actor's own hand instead of the switch bank.
  assign w_enc_in = w_force ? w_actor_avail : card_sel;

  baw_card_encoder #(
    .NUM_CARDS (NUM_CARDS)
  ) u_card_encoder (
    .i_bits  (w_enc_in),
    .i_prio  (w_force),
    .o_value (w_enc_value),
    .o_valid (w_enc_valid)
  );

  assign w_sel_mask = {{(NUM_CARDS-1){1'b0}}, 1'b1} << w_enc_value;
  assign w_legal    = w_enc_valid && (|(w_sel_mask & w_actor_avail));

  assign w_p1_card  = r_lead_is_p2 ? w_enc_value : r_lead_card;
  assign w_p2_card  = r_lead_is_p2 ? r_lead_card : w_enc_value;
  assign w_finished = (r_p1_wins == LP_WIN) || (r_p2_wins == LP_WIN) || (r_round == LP_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_p1_avail    <= '1;
      r_p2_avail    <= '1;
      r_lead_card   <= '0;
      r_follow_card <= '0;
      r_lead_is_p2  <= 1'b0;
      r_round       <= '0;
      r_p1_wins     <= '0;
      r_p2_wins     <= '0;
      r_match_res   <= RES_NONE;
      r_game_res    <= RES_NONE;
      r_sel_err     <= 1'b0;
    end else if (btn_bottom) begin
      r_state       <= S_IDLE;
      r_p1_avail    <= '1;
      r_p2_avail    <= '1;
      r_lead_card   <= '0;
      r_follow_card <= '0;
      r_lead_is_p2  <= 1'b0;
      r_round       <= '0;
      r_p1_wins     <= '0;
      r_p2_wins     <= '0;
      r_match_res   <= RES_NONE;
      r_game_res    <= RES_NONE;
      r_sel_err     <= 1'b0;
    end else begin
      r_sel_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_center) begin
            r_state    <= S_ROUND;
            r_p1_avail <= '1;
            r_p2_avail <= '1;
            r_round    <= '0;
            r_p1_wins  <= '0;
            r_p2_wins  <= '0;
          end
        end
        S_ROUND: begin
          if (w_top) begin
            r_state     <= S_LEAD;
            r_match_res <= RES_NONE;
          end
        end
        S_LEAD, S_FOLLOW: begin
          if (w_commit && w_legal) begin
            if (w_actor_is_p2) r_p2_avail <= r_p2_avail & ~w_sel_mask;
            else               r_p1_avail <= r_p1_avail & ~w_sel_mask;
            if (r_state == S_LEAD) begin
              r_lead_card <= w_enc_value;
              r_state     <= S_FOLLOW;
            end else begin
              r_follow_card <= w_enc_value;
              r_state       <= S_MATCH;
              if (r_round != LP_MAX) r_round <= r_round + CW'(1);
              if (w_p1_card > w_p2_card) begin
                r_match_res <= RES_P1;
                if (r_p1_wins != LP_MAX) r_p1_wins <= r_p1_wins + CW'(1);
              end else if (w_p2_card > w_p1_card) begin
                r_match_res <= RES_P2;
                if (r_p2_wins != LP_MAX) r_p2_wins <= r_p2_wins + CW'(1);
              end else begin
                r_match_res <= RES_DRAW;
              end
            end
          end else if (w_commit) begin
            r_sel_err <= 1'b1;
          end
        end
        S_MATCH: begin
          if (w_left) begin
            if (w_finished) begin
              r_state <= S_GAME;
              if (r_p1_wins > r_p2_wins)      r_game_res <= RES_P1;
              else if (r_p2_wins > r_p1_wins) r_game_res <= RES_P2;
              else                            r_game_res <= RES_DRAW;
            end else begin
              r_state <= S_ROUND;
              if (r_match_res == RES_P1)      r_lead_is_p2 <= 1'b0;
              else if (r_match_res == RES_P2) r_lead_is_p2 <= 1'b1;
            end
          end
        end
        S_GAME: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BAW_TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_to_flag;

  // The counter expiring on its TIMEOUT_CYC-th cycle in a turn state forces the commit.
  assign w_force = w_in_turn && !btn_bottom && !btn_top && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt  <= '0;
      r_to_flag <= 1'b0;
    end else begin
      r_to_flag <= w_force && w_legal;
      if (!w_in_turn || btn_bottom || (w_commit && w_legal)) r_to_cnt <= '0;
      else                                                   r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign to_flag = r_to_flag;
`else
  assign w_force = 1'b0;
`endif

  assign state        = r_state;
  assign p1_avail     = r_p1_avail;
  assign p2_avail     = r_p2_avail;
  assign lead_card    = r_lead_card;
  assign follow_card  = r_follow_card;
  assign lead_is_p2   = r_lead_is_p2;
  assign lead_black   = r_lead_card[0];
  assign follow_black = r_follow_card[0];
  assign round        = r_round;
  assign p1_wins      = r_p1_wins;
  assign p2_wins      = r_p2_wins;
  assign match_res    = r_match_res;
  assign game_res     = r_game_res;
  assign sel_err      = r_sel_err;

endmodule

// File: tb/tb_baw_game_ctrl.sv
// Bench for baw_game_ctrl: rule-level game model checked every cycle, directed
// scenarios with literal expectations, then randomized button/switch traffic.
module tb_baw_game_ctrl;

  localparam int N  = 9;
  localparam int CW = 4;
  localparam int VW = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         btn_center = 1'b0;
  logic         btn_top = 1'b0;
  logic         btn_bottom = 1'b0;
  logic         btn_left = 1'b0;
  logic [N-1:0] card_sel = '0;

  logic [2:0]    state;
  logic [N-1:0]  p1_avail, p2_avail;
  logic [VW-1:0] lead_card, follow_card;
  logic          lead_is_p2, lead_black, follow_black;
  logic [CW-1:0] round, p1_wins, p2_wins;
  logic [1:0]    match_res, game_res;
  logic          sel_err;

  baw_game_ctrl #(.NUM_CARDS(N), .WIN_TARGET(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_center(btn_center), .btn_top(btn_top), .btn_bottom(btn_bottom), .btn_left(btn_left),
    .card_sel(card_sel), .state(state), .p1_avail(p1_avail), .p2_avail(p2_avail),
    .lead_card(lead_card), .follow_card(follow_card), .lead_is_p2(lead_is_p2),
    .lead_black(lead_black), .follow_black(follow_black), .round(round),
    .p1_wins(p1_wins), .p2_wins(p2_wins), .match_res(match_res), .game_res(game_res),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Game model: players 0 (P1) and 1 (P2), hands as arrays of booleans.
  int m_state, m_lead, m_follow, m_leader, m_round, m_wins[2], m_mres, m_gres, m_selerr;
  bit m_hand[2][N];

  function automatic void m_reset();
    m_state = 0; m_lead = 0; m_follow = 0; m_leader = 0; m_round = 0;
    m_wins[0] = 0; m_wins[1] = 0; m_mres = 0; m_gres = 0; m_selerr = 0;
    for (int p = 0; p < 2; p++) for (int i = 0; i < N; i++) m_hand[p][i] = 1'b1;
  endfunction

  function automatic logic [N-1:0] m_mask(input int p);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_hand[p][i];
    return v;
  endfunction

  task automatic m_step();
    int ones, idx, actor, c1, c2;
    bit top, left, center;
    m_selerr = 0;
    if (btn_bottom) begin m_reset(); return; end
    top    = btn_top;
    left   = btn_left && !btn_top;
    center = btn_center && !btn_top && !btn_left;
    ones = 0; idx = 0;
    for (int i = 0; i < N; i++) if (card_sel[i]) begin ones++; idx = i; end
    case (m_state)
      0: if (center) begin
        m_state = 1; m_round = 0; m_wins[0] = 0; m_wins[1] = 0;
        for (int p = 0; p < 2; p++) for (int i = 0; i < N; i++) m_hand[p][i] = 1'b1;
      end
      1: if (top) begin m_state = 2; m_mres = 0; end
      2, 3: if (top) begin
        actor = (m_state == 2) ? m_leader : 1 - m_leader;
        if (ones == 1 && m_hand[actor][idx]) begin
          m_hand[actor][idx] = 1'b0;
          if (m_state == 2) begin
            m_lead = idx; m_state = 3;
          end else begin
            m_follow = idx; m_state = 4; m_round++;
            c1 = (m_leader == 0) ? m_lead : m_follow;
            c2 = (m_leader == 0) ? m_follow : m_lead;
            if (c1 > c2)      begin m_mres = 1; m_wins[0]++; end
            else if (c2 > c1) begin m_mres = 2; m_wins[1]++; end
            else              m_mres = 3;
          end
        end else begin
          m_selerr = 1;
        end
      end
      4: if (left) begin
        if (m_wins[0] == 5 || m_wins[1] == 5 || m_round == N) begin
          m_state = 5;
          m_gres = (m_wins[0] > m_wins[1]) ? 1 : (m_wins[1] > m_wins[0]) ? 2 : 3;
        end else begin
          m_state = 1;
          if (m_mres == 1) m_leader = 0;
          if (m_mres == 2) m_leader = 1;
        end
      end
      default: ;
    endcase
  endtask

  always @(negedge reset_n) m_reset();

  // Model advances on every edge, then all outputs are compared shortly after.
  always @(posedge clk) begin
    if (reset_n) m_step();
    #2;
    chk("state", state, m_state);
    chk("p1_avail", p1_avail, m_mask(0));
    chk("p2_avail", p2_avail, m_mask(1));
    chk("lead_card", lead_card, m_lead);
    chk("follow_card", follow_card, m_follow);
    chk("lead_black", lead_black, m_lead % 2);
    chk("follow_black", follow_black, m_follow % 2);
    chk("lead_is_p2", lead_is_p2, m_leader);
    chk("round", round, m_round);
    chk("p1_wins", p1_wins, m_wins[0]);
    chk("p2_wins", p2_wins, m_wins[1]);
    chk("match_res", match_res, m_mres);
    chk("sel_err", sel_err, m_selerr);
    if (m_state == 5) chk("game_res", game_res, m_gres);
  end

  task automatic press(input bit c, input bit t, input bit l, input bit b, input logic [N-1:0] sel);
    @(negedge clk);
    btn_center = c; btn_top = t; btn_left = l; btn_bottom = b; card_sel = sel;
    @(negedge clk);
    btn_center = 0; btn_top = 0; btn_left = 0; btn_bottom = 0;
  endtask

  task automatic top(input logic [N-1:0] sel);
    press(0, 1, 0, 0, sel);
  endtask

  task automatic play(input logic [N-1:0] lead_sel, input logic [N-1:0] follow_sel);
    top('0);
    top(lead_sel);
    top(follow_sel);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_p1_avail", p1_avail, 9'h1FF);
    reset_n = 1'b1;

    press(1, 0, 0, 0, '0);
    chk("idle_to_round", state, 1);

    play(9'h010, 9'h008);
    chk("r1_match_res", match_res, 2'b01);
    chk("r1_p1_wins", p1_wins, 1);
    chk("r1_p1_avail", p1_avail, 9'h1EF);
    chk("r1_p2_avail", p2_avail, 9'h1F7);
    chk("r1_round", round, 1);
    chk("r1_follow_black", follow_black, 1);
    press(0, 0, 1, 0, '0);
    chk("r1_next_leader", lead_is_p2, 0);
    chk("r1_back_round", state, 1);

    top('0);
    chk("lead_entry_clear", match_res, 2'b00);
    top(9'h011);
    chk("twohot_sel_err", sel_err, 1);
    chk("twohot_stays_lead", state, 2);
    @(negedge clk);
    chk("sel_err_one_cycle", sel_err, 0);
    top(9'h010);
    chk("reuse_sel_err", sel_err, 1);
    chk("reuse_stays_lead", state, 2);

    top(9'h001);
    top(9'h100);
    chk("r2_match_res", match_res, 2'b10);
    chk("r2_p2_wins", p2_wins, 1);
    press(0, 0, 1, 0, '0);
    chk("r2_winner_leads", lead_is_p2, 1);

    play(9'h080, 9'h080);
    chk("draw_match_res", match_res, 2'b11);
    chk("draw_p1_wins", p1_wins, 1);
    chk("draw_p2_wins", p2_wins, 1);
    press(0, 0, 1, 0, '0);
    chk("draw_leader_kept", lead_is_p2, 1);

    top('0);
    top(9'h002);
    chk("mid_follow", state, 3);
    chk("mid_round", round, 3);
    #1 reset_n = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_p1_avail", p1_avail, 9'h1FF);
    chk("async_p2_avail", p2_avail, 9'h1FF);
    chk("async_tallies", {p1_wins, p2_wins, round}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    press(1, 0, 0, 0, '0);
    for (int r = 0; r < 5; r++) begin
      logic [N-1:0] a, b;
      a = 9'h100 >> r;
      b = 9'h010 >> r;
      play(a, b);
      press(0, 0, 1, 0, '0);
      if (r == 3) chk("four_wins_continue", state, 1);
    end
    chk("early_finish_state", state, 5);
    chk("early_finish_game_res", game_res, 2'b01);
    chk("early_finish_round", round, 5);
    chk("early_finish_p1_wins", p1_wins, 5);
    press(0, 1, 1, 0, '0);
    chk("game_holds", state, 5);
    press(0, 0, 0, 1, '0);
    chk("bottom_reset_state", state, 0);
    chk("bottom_reset_avail", p1_avail, 9'h1FF);

    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      btn_top    = ($urandom_range(0, 99) < 35);
      btn_left   = ($urandom_range(0, 99) < 25);
      btn_center = ($urandom_range(0, 99) < 20);
      btn_bottom = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) < 8) card_sel = 9'h001 << $urandom_range(0, N - 1);
      else                          card_sel = N'($urandom);
    end
    @(negedge clk);
    btn_top = 0; btn_left = 0; btn_center = 0; btn_bottom = 0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
